// File: rtl/splitstreamer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : splitstreamer_pkg
// Purpose  : Shared constants for the splitstreamer playout path:
//            FSM state encodings, tick pipeline stage indices and the
//            occupancy counter width for the default FIFO depth.
// Revision : 1.0  initial release
// ============================================================================
package splitstreamer_pkg;

    // Playout FSM encodings (also visible on the state output)
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PREFILL = 2'd1;
    localparam logic [1:0] ST_PLAY    = 2'd2;

    // Tick pipeline: T0 is the accepted tick, T1..T3 are registered stages.
    // Bit (STAGE_Tn - 1) of the stage-valid vector marks stage Tn.
    localparam int unsigned STAGE_T1    = 1;
    localparam int unsigned STAGE_T2    = 2;
    localparam int unsigned STAGE_T3    = 3;
    localparam int unsigned PIPE_STAGES = STAGE_T3;

    // Occupancy counter width for the default 16-entry FIFO
    localparam int unsigned DEFAULT_DEPTH = 16;
    localparam int unsigned LEVEL_W       = $clog2(DEFAULT_DEPTH + 1);

    // Counter width needed to represent 0..depth inclusive
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage : splitstreamer_pkg
`default_nettype wire

// File: rtl/fifo_level_tracker.sv
`default_nettype none
// ============================================================================
// Module   : fifo_level_tracker
// Purpose  : Up/down saturating counter mirroring the occupancy of the
//            stereo sample FIFO. Simultaneous increment and decrement
//            cancel out; the count is clamped to 0..DEPTH.
// Revision : 1.0  initial release
// ============================================================================
module fifo_level_tracker
    import splitstreamer_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned LEVEL_W = splitstreamer_pkg::LEVEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_inc,
    input  logic               i_dec,
    output logic [LEVEL_W-1:0] o_level
);

    localparam logic [LEVEL_W-1:0] c_MAX_LVL = LEVEL_W'(DEPTH);

    logic [LEVEL_W-1:0] r_level;

    // Occupancy counter; saturates at both ends so a glitching flag can
    // never wrap the mirrored level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else if (i_inc && !i_dec) begin
            if (r_level != c_MAX_LVL) begin
                r_level <= r_level + 1'b1;
            end
        end else if (i_dec && !i_inc) begin
            if (r_level != '0) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule : fifo_level_tracker
`default_nettype wire

// File: rtl/fifo_playout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_playout_ctrl
// Purpose  : Read-side scheduler for the splitstreamer stereo sample FIFO.
//            Prefills to a threshold, then issues one FIFO read per S/PDIF
//            frame tick through a fixed 3-stage pipeline. Underruns output
//            a silent sample, set a sticky flag and return to prefill.
// Config   : HOLD_LAST_ON_UNDERRUN_EN - when defined, silent ticks repeat
//            the previous sample instead of outputting zeros.
// Revision : 1.0  initial release
// ============================================================================
module fifo_playout_ctrl
    import splitstreamer_pkg::*;
#(
    parameter int unsigned WORDSIZE = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned PREFILL  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         frame_tick,
    input  logic                         fifo_write_en,
    input  logic                         fifo_full,
    input  logic                         fifo_empty,
    input  logic [WORDSIZE-1:0]          fifo_left,
    input  logic [WORDSIZE-1:0]          fifo_right,
    input  logic                         underrun_clr,
    output logic                         fifo_read_en,
    output logic [WORDSIZE-1:0]          sample_left,
    output logic [WORDSIZE-1:0]          sample_right,
    output logic                         sample_valid,
    output logic                         underrun,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [1:0]                   state
);

    localparam int unsigned        c_LEVEL_W     = level_width(DEPTH);
    localparam logic [c_LEVEL_W-1:0] c_PREFILL_LVL = c_LEVEL_W'(PREFILL);
    localparam int unsigned        c_IDX_T1      = STAGE_T1 - 1;
    localparam int unsigned        c_IDX_T2      = STAGE_T2 - 1;
    localparam int unsigned        c_IDX_T3      = STAGE_T3 - 1;

    logic [1:0]               r_state;
    logic [PIPE_STAGES-1:0]   r_pipe_vld;   // stage-valid shift register, bit0 = T1
    logic [c_IDX_T2:0]        r_pipe_real;  // stage carries a real FIFO read
    logic                     r_read_en;
    logic                     r_underrun;
    logic [WORDSIZE-1:0]      r_sample_left;
    logic [WORDSIZE-1:0]      r_sample_right;

    logic [c_LEVEL_W-1:0]     w_level;
    logic                     w_lvl_inc;
    logic                     w_lvl_dec;
    logic                     w_busy;
    logic                     w_accept;
    logic                     w_real_read;
    logic                     w_underrun_tick;
    logic [WORDSIZE-1:0]      w_silent_left;
    logic [WORDSIZE-1:0]      w_silent_right;

    // Occupancy mirror: counts accepted writes and effective reads
    assign w_lvl_inc = fifo_write_en && !fifo_full;
    assign w_lvl_dec = r_read_en && !fifo_empty;

    fifo_level_tracker #(
        .DEPTH   (DEPTH),
        .LEVEL_W (c_LEVEL_W)
    ) u_level_tracker (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_lvl_inc),
        .i_dec   (w_lvl_dec),
        .o_level (w_level)
    );

    // A tick is taken only when streaming, out of IDLE, and no earlier tick
    // is still in flight; the state seen here decides read vs. silence.
    assign w_busy          = |r_pipe_vld;
    assign w_accept        = frame_tick && enable && (r_state != ST_IDLE) && !w_busy;
    assign w_real_read     = w_accept && (r_state == ST_PLAY) && !fifo_empty;
    assign w_underrun_tick = w_accept && (r_state == ST_PLAY) && fifo_empty;

`ifdef HOLD_LAST_ON_UNDERRUN_EN
    assign w_silent_left  = r_sample_left;
    assign w_silent_right = r_sample_right;
`else
    assign w_silent_left  = '0;
    assign w_silent_right = '0;
`endif

    // Playout FSM; dropping enable forces IDLE from any state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (!enable) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_PREFILL;
                end
                ST_PREFILL: begin
                    if (w_level >= c_PREFILL_LVL) begin
                        r_state <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (w_underrun_tick) begin
                        r_state <= ST_PREFILL;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Tick pipeline: advances regardless of enable so an in-flight tick
    // always completes with its T3 sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld  <= '0;
            r_pipe_real <= '0;
            r_read_en   <= 1'b0;
        end else begin
            r_pipe_vld  <= {r_pipe_vld[PIPE_STAGES-2:0], w_accept};
            r_pipe_real <= {r_pipe_real[c_IDX_T1], w_real_read};
            r_read_en   <= w_real_read;
        end
    end

    // Sample register: loads FIFO data (valid in T2) or silence at T3
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_left  <= '0;
            r_sample_right <= '0;
        end else if (r_pipe_vld[c_IDX_T2]) begin
            if (r_pipe_real[c_IDX_T2]) begin
                r_sample_left  <= fifo_left;
                r_sample_right <= fifo_right;
            end else begin
                r_sample_left  <= w_silent_left;
                r_sample_right <= w_silent_right;
            end
        end
    end

    // Sticky underrun flag; a new underrun beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
        end else if (w_underrun_tick) begin
            r_underrun <= 1'b1;
        end else if (underrun_clr) begin
            r_underrun <= 1'b0;
        end
    end

    assign fifo_read_en = r_read_en;
    assign sample_left  = r_sample_left;
    assign sample_right = r_sample_right;
    assign sample_valid = r_pipe_vld[c_IDX_T3];
    assign underrun     = r_underrun;
    assign level        = w_level;
    assign state        = r_state;

endmodule : fifo_playout_ctrl
`default_nettype wire

// File: tb/tb_fifo_playout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_playout_ctrl
// Purpose  : Directed self-checking bench for fifo_playout_ctrl with a
//            behavioural stereo FIFO and a sample scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_playout_ctrl;

    localparam int WS    = 32;
    localparam int DEPTH = 16;
    localparam int PF    = 8;
    localparam int LW    = $clog2(DEPTH + 1);
`ifdef HOLD_LAST_ON_UNDERRUN_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          frame_tick;
    logic          fifo_write_en;
    logic          fifo_full;
    logic          fifo_empty;
    logic [WS-1:0] fifo_left;
    logic [WS-1:0] fifo_right;
    logic          underrun_clr;
    logic          fifo_read_en;
    logic [WS-1:0] sample_left;
    logic [WS-1:0] sample_right;
    logic          sample_valid;
    logic          underrun;
    logic [LW-1:0] level;
    logic [1:0]    state;

    logic [WS-1:0] wr_l, wr_r;

    int vectors    = 0;
    int miscompares = 0;
    logic [63:0] sb[$];        // expected {left,right} per sample_valid
    logic [63:0] exp_fifo[$];  // expected FIFO contents
    logic [63:0] last_smp;

    always #5 clk = ~clk;

    fifo_playout_ctrl #(.WORDSIZE(WS), .DEPTH(DEPTH), .PREFILL(PF)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .frame_tick    (frame_tick),
        .fifo_write_en (fifo_write_en),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .fifo_left     (fifo_left),
        .fifo_right    (fifo_right),
        .underrun_clr  (underrun_clr),
        .fifo_read_en  (fifo_read_en),
        .sample_left   (sample_left),
        .sample_right  (sample_right),
        .sample_valid  (sample_valid),
        .underrun      (underrun),
        .level         (level),
        .state         (state)
    );

    // Behavioural FIFO with registered outputs, sharing the block reset
    logic [WS-1:0] m_mem_l [DEPTH];
    logic [WS-1:0] m_mem_r [DEPTH];
    logic [3:0]    m_wp, m_rp;
    logic [4:0]    m_cnt;
    logic          m_w, m_r;
    assign fifo_full  = (m_cnt == 5'(DEPTH));
    assign fifo_empty = (m_cnt == 5'd0);
    assign m_w = fifo_write_en && !fifo_full;
    assign m_r = fifo_read_en && !fifo_empty;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wp <= '0; m_rp <= '0; m_cnt <= '0;
            fifo_left <= '0; fifo_right <= '0;
        end else begin
            if (m_w) begin
                m_mem_l[m_wp] <= wr_l;
                m_mem_r[m_wp] <= wr_r;
                m_wp <= m_wp + 4'd1;
            end
            if (m_r) begin
                fifo_left  <= m_mem_l[m_rp];
                fifo_right <= m_mem_r[m_rp];
                m_rp <= m_rp + 4'd1;
            end
            m_cnt <= m_cnt + 5'(m_w) - 5'(m_r);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every sample_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && sample_valid !== 1'b0) begin
            if (sb.size() == 0)
                chk("unexpected_sample_valid", {63'd0, sample_valid}, 64'd0);
            else
                chk("sample", {sample_left, sample_right}, sb.pop_front());
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr_word(input logic [WS-1:0] l, input logic [WS-1:0] r);
        fifo_write_en = 1'b1; wr_l = l; wr_r = r;
        if (exp_fifo.size() < DEPTH) exp_fifo.push_back({l, r});
        cyc();
        fifo_write_en = 1'b0;
    endtask

    // One full tick (T0..T3); expect_read says whether a FIFO read is due
    task automatic do_tick(input string tag, input bit expect_read, input bit with_write,
                           input logic [WS-1:0] l, input logic [WS-1:0] r);
        frame_tick = 1'b1;
        if (expect_read) begin
            last_smp = exp_fifo.pop_front();
            sb.push_back(last_smp);
        end else begin
            sb.push_back(HOLD ? last_smp : 64'd0);
        end
        cyc();                                 // T1
        frame_tick = 1'b0;
        chk({tag, "_rd_T1"}, {63'd0, fifo_read_en}, {63'd0, expect_read});
        if (with_write) begin
            fifo_write_en = 1'b1; wr_l = l; wr_r = r;
            exp_fifo.push_back({l, r});
        end
        cyc();                                 // T2
        fifo_write_en = 1'b0;
        chk({tag, "_rd_T2"}, {63'd0, fifo_read_en}, 64'd0);
        cyc();                                 // T3 (scoreboard checks)
        cyc();                                 // T4
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; frame_tick = 1'b0; fifo_write_en = 1'b0;
        underrun_clr = 1'b0; wr_l = '0; wr_r = '0; last_smp = '0;
        cyc(); cyc();
        chk("rst_state", state, 0);
        chk("rst_level", level, 0);
        chk("rst_outs", {sample_left, sample_right}, 0);
        chk("rst_flags", {fifo_read_en, sample_valid, underrun}, 0);

        // 1: prefill to threshold, then PLAY
        rst_n = 1'b1; enable = 1'b1;
        cyc();
        chk("t1_prefill", state, 1);
        wr_word(32'hA5, 32'h5A);
        for (int i = 1; i < 8; i++) wr_word(32'h100 + i, 32'h200 + i);
        chk("t1_level8", level, 8);
        cyc();
        chk("t1_play", state, 2);

        // 2: real read, then drain the rest
        do_tick("t2_first", 1'b1, 1'b0, 0, 0);
        chk("t2_level7", level, 7);
        for (int i = 0; i < 7; i++) do_tick("t2_drain", 1'b1, 1'b0, 0, 0);
        chk("t2_level0", level, 0);
        chk("t2_no_underrun", {63'd0, underrun}, 0);

        // 3: underrun tick on empty FIFO
        do_tick("t3_underrun", 1'b0, 1'b0, 0, 0);
        chk("t3_flag", {63'd0, underrun}, 1);
        chk("t3_state", state, 1);
        underrun_clr = 1'b1;
        cyc();
        underrun_clr = 1'b0;
        chk("t3_clear", {63'd0, underrun}, 0);

        // 4: simultaneous write/read at level 5, then saturation at full
        for (int i = 0; i < 8; i++) wr_word(32'hC00 + i, 32'hD00 + i);
        cyc();
        chk("t4_play", state, 2);
        for (int i = 0; i < 3; i++) do_tick("t4_read", 1'b1, 1'b0, 0, 0);
        chk("t4_level5", level, 5);
        do_tick("t4_rw", 1'b1, 1'b1, 32'hE0, 32'hF0);
        chk("t4_rw_level5", level, 5);
        for (int i = 0; i < 12; i++) wr_word(32'h3000 + i, 32'h4000 + i);
        chk("t4_level_full", level, 16);

        // 5a: second tick at T2 is ignored
        frame_tick = 1'b1; last_smp = exp_fifo.pop_front(); sb.push_back(last_smp);
        cyc();
        frame_tick = 1'b0;
        chk("t5_rd_T1", {63'd0, fifo_read_en}, 1);
        cyc();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("t5_no_rd_T3", {63'd0, fifo_read_en}, 0);
        cyc(); cyc(); cyc();
        chk("t5_one_read", level, 15);

        // 5b: enable drops at T1, T3 still fires, then IDLE
        frame_tick = 1'b1; last_smp = exp_fifo.pop_front(); sb.push_back(last_smp);
        cyc();
        frame_tick = 1'b0; enable = 1'b0;
        chk("t5b_rd_T1", {63'd0, fifo_read_en}, 1);
        cyc();
        chk("t5b_idle", state, 0);
        cyc(); cyc();
        chk("t5b_level", level, 14);

        // 5c: tick while still in IDLE is ignored
        enable = 1'b1; frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("t5c_no_rd", {63'd0, fifo_read_en}, 0);
        cyc(); cyc(); cyc();
        chk("t5c_play", state, 2);

        // 6: reset after T1 clears everything asynchronously
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("t6_rd_T1", {63'd0, fifo_read_en}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_samples", {sample_left, sample_right}, 0);
        chk("t6_rst_flags", {fifo_read_en, sample_valid, underrun}, 0);
        chk("t6_rst_level", level, 0);
        chk("t6_rst_state", state, 0);
        exp_fifo.delete(); last_smp = '0; enable = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        chk("t6_post_level", level, 0);
        chk("sb_drained", 64'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fifo_playout_ctrl
`default_nettype wire
